iterative_addsub: RTL and testbench

- Parametrised, multi-cycle add/subtract unit for the ALU.
- Processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, carrying the inter-slice carry in a register.
- Supports add and subtract and reports carry, borrow, signed overflow and zero.
- Sits beside the ALU functional units and is started and collected through a start/done handshake. This lets wide datapaths trade latency for a short carry chain.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/chunk_adder.sv | 41 ++++
 rtl/iterative_addsub.sv | 140 ++++++++++++++
 tb/tb_iterative_addsub.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants, state encoding and parameter check for iterative_addsub
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit chunking_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational carry look-ahead slice, also exposing the carry into its MSB
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat generate/propagate sum-of-products rather than a ripple.
    always_comb begin
        logic pp;
        logic cc;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            pp = 1'b1;
            cc = 1'b0;
            for (int j = i; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & cin);
        end
    end

    assign sum  = p ^ c[CHUNK-1:0];
    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/iterative_addsub.sv
// rtl/iterative_addsub.sv - multi-cycle CHUNK-sliced add/subtract; ADDSUB_SATURATE_EN adds saturation
module iterative_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef ADDSUB_SATURATE_EN
    input  logic             sat,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             borrowOut,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_chunk
        $fatal(1, "iterative_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] final_res;
    logic             carry_q;
    logic             op_q;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;

    assign last   = (cnt == CW'(N - 1));
    assign accept = start && (state != RUN);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // Operands shift down one slice per cycle; sums enter the shadow from the top.
    assign res_next = (res_sh >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));

`ifdef ADDSUB_SATURATE_EN
    logic sat_q;
    always_comb begin
        final_res = res_next;
        if (sat_q && (slice_cmsb ^ slice_cout))
            final_res = res_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                          : {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
    assign final_res = res_next;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            op_q      <= 1'b0;
            result    <= '0;
            carryOut  <= 1'b0;
            borrowOut <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
            sat_q     <= 1'b0;
`endif
        end else if (accept) begin
            a_sh    <= A;
            b_sh    <= (op == OP_SUB) ? ~B : B;
            op_q    <= op;
            carry_q <= op;
            cnt     <= '0;
`ifdef ADDSUB_SATURATE_EN
            sat_q   <= sat;
`endif
        end else if (state == RUN) begin
            a_sh    <= a_sh >> CHUNK;
            b_sh    <= b_sh >> CHUNK;
            res_sh  <= res_next;
            carry_q <= slice_cout;
            cnt     <= cnt + CW'(1);
            if (last) begin
                result    <= final_res;
                carryOut  <= slice_cout;
                borrowOut <= op_q & ~slice_cout;
                overflow  <= slice_cmsb ^ slice_cout;
                zero      <= (final_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_iterative_addsub.sv
// tb/tb_iterative_addsub.sv - randomized self-checking bench for iterative_addsub against an arithmetic model
module tb_iterative_addsub;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        bo;
        logic        v;
        logic        z;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        sat;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carryOut;
    logic        borrowOut;
    logic        overflow;
    logic        zero;

    iterative_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (a_in),
        .B         (b_in),
`ifdef ADDSUB_SATURATE_EN
        .sat       (sat),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carryOut  (carryOut),
        .borrowOut (borrowOut),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    int   acc_at   = -1;
    int   done_at  = -1;
    exp_t pend     = '0;
    exp_t held     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic o, input logic s);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sr;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sr = o ? (sa - sb) : (sa + sb);
        e.res = o ? (a - b) : (a + b);
        e.c   = o ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
        e.bo  = o & ~e.c;
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (s && e.v) e.res = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.z   = (e.res == 32'd0);
        return e;
    endfunction

    always @(negedge clock) begin
        if (cyc == done_at) held = pend;
        chk("done", done, (cyc == done_at));
        chk("busy", busy, (acc_at >= 0 && cyc >= acc_at && cyc < done_at));
        chk("result", result, held.res);
        chk("carryOut", carryOut, held.c);
        chk("borrowOut", borrowOut, held.bo);
        chk("overflow", overflow, held.v);
        chk("zero", zero, held.z);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic o, input logic s);
        int   guard = 0;
        logic sv    = s;
`ifndef ADDSUB_SATURATE_EN
        sv = 1'b0;
`endif
        while (done_at >= 0 && cyc < done_at && guard < 50) begin
            step();
            guard++;
        end
        a_in    = a;
        b_in    = b;
        op      = o;
        sat     = sv;
        start   = 1'b1;
        pend    = model(a, b, o, sv);
        acc_at  = cyc + 1;
        done_at = cyc + 1 + N;
        step();
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        op    = 1'($urandom);
        sat   = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within 20 cycles, expected at cycle %0d", done_at);
        end
    endtask

    initial begin
        int prev_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        sat   = 1'b0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        reset = 1'b0;
        step();

        start_op(32'd5, 32'd3, 1'b1, 1'b0);
        wait_done();
        chk("lat_5m3", cyc - (acc_at - 1), 5);
        chk("res_5m3", result, 32'h0000_0002);
        chk("c_5m3", carryOut, 1);
        chk("bo_5m3", borrowOut, 0);
        chk("v_5m3", overflow, 0);
        chk("z_5m3", zero, 0);

        start_op(32'd3, 32'd5, 1'b1, 1'b0);
        wait_done();
        chk("res_3m5", result, 32'hFFFF_FFFE);
        chk("bo_3m5", borrowOut, 1);
        chk("v_3m5", overflow, 0);

        start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_done();
        chk("res_ff_p1", result, 32'h0);
        chk("c_ff_p1", carryOut, 1);
        chk("z_ff_p1", zero, 1);

        start_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_done();
        chk("res_7f_p1", result, 32'h8000_0000);
        chk("v_7f_p1", overflow, 1);
`ifdef ADDSUB_SATURATE_EN
        start_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        wait_done();
        chk("res_7f_p1_sat", result, 32'h7FFF_FFFF);
        chk("v_7f_p1_sat", overflow, 1);
        start_op(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        wait_done();
        chk("res_80_m1_sat", result, 32'h8000_0000);
`endif

        // A second start while busy must be ignored.
        start_op(32'd100, 32'd23, 1'b0, 1'b0);
        step();
        a_in  = 32'd999;
        b_in  = 32'd1;
        op    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        chk("res_ignore", result, 32'd123);
        repeat (8) step();

        // Reset in the middle of RUN aborts the operation.
        start_op(32'd1, 32'd2, 1'b0, 1'b0);
        step();
        reset   = 1'b1;
        acc_at  = -1;
        done_at = -1;
        pend    = '0;
        held    = '0;
        step();
        reset = 1'b0;
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_result", result, 0);
        start_op(32'd10, 32'd20, 1'b0, 1'b0);
        wait_done();
        chk("res_10p20", result, 32'd30);
        chk("lat_10p20", cyc - (acc_at - 1), 5);

        // Back-to-back: start held in the done cycle.
        prev_done = cyc;
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_done();
        chk("b2b_spacing", cyc - prev_done, N + 1);
        chk("b2b_res", result, 32'h2345_6789);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h7FFF_FFFF;
                1: rb = 32'h8000_0000;
                2: rb = ra;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) step();
            start_op(ra, rb, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0) wait_done();
        end
        wait_done();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
